// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect bus: jump-controller / hazard-unit requests toward the PC
// owner, and the fetch address, kill and statistics outputs coming back.
interface fetch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic            stall;
  logic            imem_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            if_valid;
  logic            ifid_flush;
  logic            idex_flush;
  logic            pc_misalign;
  logic [31:0]     redirect_cnt;
  logic [31:0]     bubble_cnt;

  modport master (
    output flush, pc_sel, branch_target, jump_target, stall, imem_ready,
    input  pc, pc_plus4, if_valid, ifid_flush, idex_flush, pc_misalign,
           redirect_cnt, bubble_cnt
  );

  modport slave (
    input  flush, pc_sel, branch_target, jump_target, stall, imem_ready,
    output pc, pc_plus4, if_valid, ifid_flush, idex_flush, pc_misalign,
           redirect_cnt, bubble_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Program counter owner for the IF stage: applies EX-stage redirects,
// holds them across instruction-memory back-pressure, and kills IF/ID, ID/EX.
// Optional redirect/bubble statistics counters: define FETCH_REDIRECT_STATS_EN.
//
// state | meaning
// RUN   | normal fetch, PC advances unless stalled or memory not ready
// PEND  | redirect accepted, target held in target_q until imem_ready
module fetch_redirect_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  fetch_redirect_ctrl_if.slave bus
);

  typedef enum logic {RUN, PEND} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            if_valid_q, if_valid_d;
  logic            misalign_q;
  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_flush;

  assign redirect    = bus.flush && (bus.pc_sel == 2'b01 || bus.pc_sel == 2'b10);
  assign target_raw  = (bus.pc_sel == 2'b01) ? bus.branch_target : bus.jump_target;
  assign target      = {target_raw[XLEN-1:2], 2'b00};
  // In PEND a fresh redirect replaces the held target (newest wins)
  assign pend_target = redirect ? target : target_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign ifid_flush  = bus.flush || (state_q == PEND);

  // Next-state, next-PC and held-target selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    if_valid_d = !(ifid_flush || (state_q == RUN && !bus.imem_ready));
    case (state_q)
      RUN: begin
        if (redirect) begin
          if (bus.imem_ready) begin
            pc_d = target;
          end else begin
            target_d = target;
            state_d  = PEND;
          end
        end else if (!bus.stall && bus.imem_ready) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        target_d = pend_target;
        if (bus.imem_ready) begin
          pc_d    = pend_target;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, PC, held target and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      if_valid_q <= if_valid_d;
      misalign_q <= redirect && (target_raw[1:0] != 2'b00);
    end
  end

`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Saturating counts of taken redirects and IF/ID kill cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_cnt_q <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      if (redirect && redirect_cnt_q != 32'hFFFF_FFFF)
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (ifid_flush && bubble_cnt_q != 32'hFFFF_FFFF)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.bubble_cnt   = bubble_cnt_q;
`else
  assign bus.redirect_cnt = 32'd0;
  assign bus.bubble_cnt   = 32'd0;
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.if_valid    = if_valid_q;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = bus.flush;
  assign bus.pc_misalign = misalign_q;

endmodule
